// File: rtl/led_ctrl_pkg.sv
// led_ctrl_pkg: shared types and helpers for the LED pattern controller.
//   mode_t     - 3-bit display mode encoding (6 and 7 are unused)
//   NUM_MODES  - number of legal display modes
//   next_mode  - successor of a mode in the press-driven cycle
package led_ctrl_pkg;

  typedef enum logic [2:0] {
    MODE_OFF        = 3'd0,
    MODE_ALL_ON     = 3'd1,
    MODE_BLINK_SLOW = 3'd2,
    MODE_BLINK_FAST = 3'd3,
    MODE_CHASE      = 3'd4,
    MODE_COUNT      = 3'd5
  } mode_t;

  localparam int unsigned NUM_MODES = 6;

  // Unused encodings fall back to OFF so a corrupted register self-recovers.
  function automatic mode_t next_mode(input mode_t cur);
    mode_t nxt;
    case (cur)
      MODE_OFF:        nxt = MODE_ALL_ON;
      MODE_ALL_ON:     nxt = MODE_BLINK_SLOW;
      MODE_BLINK_SLOW: nxt = MODE_BLINK_FAST;
      MODE_BLINK_FAST: nxt = MODE_CHASE;
      MODE_CHASE:      nxt = MODE_COUNT;
      default:         nxt = MODE_OFF;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/led_debounce.sv
// led_debounce: synchronises and debounces a raw push-button.
//   clk, rst_n - system clock, asynchronous active-low reset
//   button     - raw asynchronous button level (high = pressed)
//   stable     - debounced button level
//   press      - one-cycle strobe on each accepted 0->1 change of stable
module led_debounce
  import led_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button,
  output logic stable,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_1;
  logic          btn_s;
  logic [CW-1:0] cnt;
  logic          accept;

  // Accept on the cycle the mismatch count would reach DEBOUNCE_CYCLES, so
  // stable and press update on the same edge the counter completes.
  assign accept = (btn_s != stable) && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= 1'b0;
      btn_s  <= 1'b0;
    end else begin
      sync_1 <= button;
      btn_s  <= sync_1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      stable <= 1'b0;
      press  <= 1'b0;
    end else begin
      press <= accept && btn_s;
      if (btn_s == stable) begin
        cnt <= '0;
      end else if (accept) begin
        cnt    <= '0;
        stable <= btn_s;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_pattern_controller.sv
// led_pattern_controller: button-stepped multi-mode LED pattern generator.
//   clk, rst_n - system clock, asynchronous active-low reset
//   button     - raw push-button (high = pressed)
//   leds       - registered LED drive, NUM_LEDS wide (high = lit)
//   clk_slow   - square wave, period 2*SLOW_HALF clk cycles
//   clk_fast   - square wave, period 2*FAST_HALF clk cycles
//   mode       - current display mode encoding
//   press      - one-cycle strobe per accepted button press
module led_pattern_controller
  import led_ctrl_pkg::*;
#(
  parameter int unsigned NUM_LEDS        = 3,
  parameter int unsigned SLOW_HALF       = 50_000_000,
  parameter int unsigned FAST_HALF       = 12_500_000,
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                button,
  output logic [NUM_LEDS-1:0] leds,
  output logic                clk_slow,
  output logic                clk_fast,
  output logic [2:0]          mode,
  output logic                press
);

  localparam int unsigned SW = $clog2(SLOW_HALF);
  localparam int unsigned FW = $clog2(FAST_HALF);
  localparam logic [SW-1:0] SLOW_LAST = SW'(SLOW_HALF - 1);
  localparam logic [FW-1:0] FAST_LAST = FW'(FAST_HALF - 1);
  localparam logic [NUM_LEDS-1:0] CHASE_SEED = NUM_LEDS'(1);

  logic                btn_level;
  logic [SW-1:0]       slow_cnt;
  logic [FW-1:0]       fast_cnt;
  logic                fast_rise;
  mode_t               mode_q;
  mode_t               mode_d;
  logic [NUM_LEDS-1:0] pattern;
  logic [NUM_LEDS-1:0] leds_d;

  led_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .button(button),
    .stable(btn_level),
    .press (press)
  );

  // A press can only be reported together with a pressed debounced level.
  press_with_level : assert property (@(posedge clk) disable iff (!rst_n)
    press |-> btn_level);

  // Free-running dividers; never restarted by mode changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slow_cnt <= '0;
      clk_slow <= 1'b0;
    end else if (slow_cnt == SLOW_LAST) begin
      slow_cnt <= '0;
      clk_slow <= ~clk_slow;
    end else begin
      slow_cnt <= slow_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fast_cnt <= '0;
      clk_fast <= 1'b0;
    end else if (fast_cnt == FAST_LAST) begin
      fast_cnt <= '0;
      clk_fast <= ~clk_fast;
    end else begin
      fast_cnt <= fast_cnt + 1'b1;
    end
  end

  // High in the cycle whose closing edge takes clk_fast from 0 to 1.
  assign fast_rise = (fast_cnt == FAST_LAST) && !clk_fast;

  // Mode FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_OFF;
    end else begin
      mode_q <= mode_d;
    end
  end

  // Mode FSM: next state
  always_comb begin
    mode_d = mode_q;
    case (mode_q)
      MODE_OFF, MODE_ALL_ON, MODE_BLINK_SLOW,
      MODE_BLINK_FAST, MODE_CHASE, MODE_COUNT: begin
        if (press) begin
          mode_d = next_mode(mode_q);
        end
      end
      default: mode_d = MODE_OFF;
    endcase
  end

  // Shared chase/count register. The mode-entry load is checked before
  // fast_rise so that a simultaneous press wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern <= '0;
    end else if (press) begin
      pattern <= (next_mode(mode_q) == MODE_CHASE) ? CHASE_SEED : '0;
    end else if (fast_rise) begin
      case (mode_q)
        MODE_CHASE: pattern <= {pattern[NUM_LEDS-2:0], pattern[NUM_LEDS-1]};
        MODE_COUNT: pattern <= pattern + 1'b1;
        default:    pattern <= pattern;
      endcase
    end
  end

  // Mode FSM: outputs
  always_comb begin
    leds_d = '0;
    case (mode_q)
      MODE_ALL_ON:     leds_d = '1;
      MODE_BLINK_SLOW: leds_d = {NUM_LEDS{clk_slow}};
      MODE_BLINK_FAST: leds_d = {NUM_LEDS{clk_fast}};
      MODE_CHASE,
      MODE_COUNT:      leds_d = pattern;
      default:         leds_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      leds <= '0;
    end else begin
      leds <= leds_d;
    end
  end

  assign mode = mode_q;

endmodule
